// File: rtl/line_attack_scheduler.sv
// Battle-mode attack/garbage scheduler: turns row clears into attack lines and queues opponent garbage.
// Latency: every output is registered, so an input sampled at edge t shows up one cycle later.
// Backpressure: ins_req stays high until ins_ack arrives; send pulses and the garbage queue are never stalled.
module line_attack_scheduler #(
  parameter int MAX_PENDING = 7,
  parameter int PENDING_W   = 3,
  parameter int HOLE_STEP   = 3
) (
  input  logic                 clk_6,
  input  logic                 rst,
  input  logic                 line_cleared,
  input  logic                 clear_done,
  input  logic                 game_addLine,
  output logic                 game_sendLine,
  output logic                 ins_req,
  input  logic                 ins_ack,
  output logic [9:0]           ins_row,
  output logic [PENDING_W-1:0] pending,
  output logic                 overflow
);

  typedef enum logic [1:0] {IDLE, COUNT, SEND, INSERT} state_t;

  localparam int CW = (PENDING_W > 3) ? PENDING_W : 3;
  localparam logic [PENDING_W-1:0] PMAX = PENDING_W'(MAX_PENDING);

  state_t               state, state_nxt;
  logic [2:0]           clr_cnt, clr_cnt_nxt, clr_eff, attack;
  logic [2:0]           send_cnt, send_cnt_nxt;
  logic [3:0]           hole, hole_nxt;
  logic [4:0]           hole_sum;
  logic [CW-1:0]        attack_w, pend_w, cancel_w;
  logic [PENDING_W-1:0] dec, pend_dec, pending_nxt;
  logic                 send_nxt, req_nxt, ovf_nxt;
  logic                 counting, clear_now, ack_now;

  always_ff @(posedge clk_6) begin
    if (rst) begin
      state         <= IDLE;
      clr_cnt       <= '0;
      send_cnt      <= '0;
      pending       <= '0;
      hole          <= '0;
      game_sendLine <= 1'b0;
      ins_req       <= 1'b0;
      overflow      <= 1'b0;
      ins_row       <= 10'h3FE;
    end else begin
      state         <= state_nxt;
      clr_cnt       <= clr_cnt_nxt;
      send_cnt      <= send_cnt_nxt;
      pending       <= pending_nxt;
      hole          <= hole_nxt;
      game_sendLine <= send_nxt;
      ins_req       <= req_nxt;
      overflow      <= ovf_nxt;
      ins_row       <= ~(10'd1 << hole_nxt);
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_cnt_nxt  = clr_cnt;
    send_cnt_nxt = send_cnt;
    hole_nxt     = hole;
    send_nxt     = 1'b0;
    req_nxt      = ins_req;
    ovf_nxt      = overflow;
    dec          = '0;

    counting  = (state == IDLE) || (state == COUNT);
    clear_now = counting && clear_done;
    ack_now   = (state == INSERT) && ins_req && ins_ack;

    // A clear landing in the same cycle as clear_done still counts toward the attack.
    clr_eff = clr_cnt;
    if (counting && line_cleared && (clr_cnt != 3'd4))
      clr_eff = clr_cnt + 3'd1;

    case (clr_eff)
      3'd2:    attack = 3'd1;
      3'd3:    attack = 3'd2;
      3'd4:    attack = 3'd4;
      default: attack = 3'd0;
    endcase

    attack_w = CW'(attack);
    pend_w   = CW'(pending);
    cancel_w = (attack_w < pend_w) ? attack_w : pend_w;

    if (clear_now)
      dec = PENDING_W'(cancel_w);
    else if (ack_now)
      dec = PENDING_W'(1);

    // Decrement first, then add; overflow only when a full queue gets no relief.
    pend_dec    = pending - dec;
    pending_nxt = pend_dec;
    if (game_addLine) begin
      if (pend_dec >= PMAX) begin
        pending_nxt = PMAX;
        if (dec == '0)
          ovf_nxt = 1'b1;
      end else begin
        pending_nxt = pend_dec + PENDING_W'(1);
      end
    end

    hole_sum = 5'(hole) + 5'(HOLE_STEP);

    case (state)
      IDLE, COUNT: begin
        clr_cnt_nxt = clr_eff;
        if (line_cleared)
          state_nxt = COUNT;
        if (clear_done) begin
          clr_cnt_nxt  = '0;
          send_cnt_nxt = 3'(attack_w - cancel_w);
          if (attack_w != cancel_w) begin
            state_nxt = SEND;
            send_nxt  = 1'b1;
          end else if (pending_nxt != '0) begin
            state_nxt = INSERT;
            req_nxt   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      SEND: begin
        if (game_sendLine) begin
          send_cnt_nxt = send_cnt - 3'd1;
        end else if (send_cnt != 3'd0) begin
          send_nxt = 1'b1;
        end else if (pending_nxt != '0) begin
          state_nxt = INSERT;
          req_nxt   = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      INSERT: begin
        if (ins_req) begin
          if (ins_ack) begin
            req_nxt  = 1'b0;
            hole_nxt = (hole_sum >= 5'd10) ? 4'(hole_sum - 5'd10) : 4'(hole_sum);
          end
        end else if (pending_nxt != '0) begin
          req_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_line_attack_scheduler.sv
// Directed bench for line_attack_scheduler: reset, attack sends, cancel/insert, overflow, reset mid-send.
module tb_line_attack_scheduler;

  logic       clk_6 = 1'b0;
  logic       rst = 1'b0;
  logic       line_cleared = 1'b0;
  logic       clear_done = 1'b0;
  logic       game_addLine = 1'b0;
  logic       ins_ack = 1'b0;
  logic       game_sendLine;
  logic       ins_req;
  logic [9:0] ins_row;
  logic [2:0] pending;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk_6 = ~clk_6;

  line_attack_scheduler #(.MAX_PENDING(7), .PENDING_W(3), .HOLE_STEP(3)) dut (
    .clk_6(clk_6),
    .rst(rst),
    .line_cleared(line_cleared),
    .clear_done(clear_done),
    .game_addLine(game_addLine),
    .game_sendLine(game_sendLine),
    .ins_req(ins_req),
    .ins_ack(ins_ack),
    .ins_row(ins_row),
    .pending(pending),
    .overflow(overflow)
  );

  task automatic tick;
    @(posedge clk_6);
    #1;
  endtask

  task automatic pulse_clear(input int n);
    for (int i = 0; i < n; i++) begin
      line_cleared = 1'b1;
      tick();
      line_cleared = 1'b0;
    end
  endtask

  task automatic pulse_add(input int n);
    for (int i = 0; i < n; i++) begin
      game_addLine = 1'b1;
      tick();
      game_addLine = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests++; if (game_sendLine !== 1'b0) begin fails++; $display("FAIL reset_sendLine: got %b expected 0", game_sendLine); end
    tests++; if (ins_req !== 1'b0) begin fails++; $display("FAIL reset_ins_req: got %b expected 0", ins_req); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    tests++; if (ins_row !== 10'h3FE) begin fails++; $display("FAIL reset_ins_row: got %h expected 3fe", ins_row); end
    tests++; if (pending !== 3'd0) begin fails++; $display("FAIL reset_pending: got %0d expected 0", pending); end
  endtask

  task automatic test_double_clear;
    int highs, reqs;
    highs = 0;
    reqs  = 0;
    pulse_clear(2);
    clear_done = 1'b1;
    tick();
    clear_done = 1'b0;
    tests++; if (game_sendLine !== 1'b1) begin fails++; $display("FAIL dbl_pulse_t1: got %b expected 1", game_sendLine); end
    tests++; if (ins_req !== 1'b0) begin fails++; $display("FAIL dbl_req_t1: got %b expected 0", ins_req); end
    tick();
    tests++; if (game_sendLine !== 1'b0) begin fails++; $display("FAIL dbl_pulse_t2: got %b expected 0", game_sendLine); end
    for (int k = 0; k < 8; k++) begin
      tick();
      if (game_sendLine === 1'b1) highs++;
      if (ins_req === 1'b1) reqs++;
    end
    tests++; if (highs !== 0) begin fails++; $display("FAIL dbl_extra_pulses: got %0d expected 0", highs); end
    tests++; if (reqs !== 0) begin fails++; $display("FAIL dbl_ins_req: got %0d cycles expected 0", reqs); end
  endtask

  // pre clears before clear_done; same_cycle adds one more clear alongside clear_done.
  task automatic test_four_row(input int pre, input bit same_cycle);
    logic [11:0] seen;
    seen = '0;
    pulse_clear(pre);
    clear_done   = 1'b1;
    line_cleared = same_cycle;
    tick();
    clear_done   = 1'b0;
    line_cleared = 1'b0;
    for (int k = 0; k < 12; k++) begin
      seen[k] = game_sendLine;
      tick();
    end
    tests++;
    if (seen !== 12'h055) begin
      fails++;
      $display("FAIL four_row_pattern(pre=%0d,same=%0d): got %h expected 055", pre, same_cycle, seen);
    end
  endtask

  task automatic test_cancel_insert;
    int highs;
    highs = 0;
    pulse_add(3);
    tests++; if (pending !== 3'd3) begin fails++; $display("FAIL cancel_pending_pre: got %0d expected 3", pending); end
    pulse_clear(2);
    clear_done = 1'b1;
    tick();
    clear_done = 1'b0;
    if (game_sendLine === 1'b1) highs++;
    tests++; if (pending !== 3'd2) begin fails++; $display("FAIL cancel_pending: got %0d expected 2", pending); end
    tests++; if (ins_req !== 1'b1) begin fails++; $display("FAIL cancel_req_t1: got %b expected 1", ins_req); end
    tests++; if (ins_row !== 10'h3FE) begin fails++; $display("FAIL cancel_row1: got %h expected 3fe", ins_row); end
    ins_ack = 1'b1;
    tick();
    if (game_sendLine === 1'b1) highs++;
    tests++; if (ins_req !== 1'b0) begin fails++; $display("FAIL cancel_req_drop: got %b expected 0", ins_req); end
    tests++; if (pending !== 3'd1) begin fails++; $display("FAIL cancel_pending_ack1: got %0d expected 1", pending); end
    // ack held into the low cycle must be ignored
    tick();
    ins_ack = 1'b0;
    if (game_sendLine === 1'b1) highs++;
    tests++; if (ins_req !== 1'b1) begin fails++; $display("FAIL cancel_req_reassert: got %b expected 1", ins_req); end
    tests++; if (pending !== 3'd1) begin fails++; $display("FAIL cancel_ack_while_low: got %0d expected 1", pending); end
    tests++; if (ins_row !== 10'h3F7) begin fails++; $display("FAIL cancel_row2: got %h expected 3f7", ins_row); end
    ins_ack = 1'b1;
    tick();
    ins_ack = 1'b0;
    tests++; if (pending !== 3'd0) begin fails++; $display("FAIL cancel_pending_final: got %0d expected 0", pending); end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (game_sendLine === 1'b1) highs++;
    end
    tests++; if (ins_req !== 1'b0) begin fails++; $display("FAIL cancel_idle_req: got %b expected 0", ins_req); end
    tests++; if (highs !== 0) begin fails++; $display("FAIL cancel_send_pulses: got %0d expected 0", highs); end
  endtask

  task automatic test_overflow;
    pulse_add(7);
    tests++; if (pending !== 3'd7) begin fails++; $display("FAIL ovf_pending7: got %0d expected 7", pending); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_early: got %b expected 0", overflow); end
    pulse_add(1);
    tests++; if (pending !== 3'd7) begin fails++; $display("FAIL ovf_pending_sat: got %0d expected 7", pending); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    clear_done = 1'b1;
    tick();
    clear_done = 1'b0;
    tests++; if (ins_req !== 1'b1) begin fails++; $display("FAIL ovf_req: got %b expected 1", ins_req); end
    ins_ack      = 1'b1;
    game_addLine = 1'b1;
    tick();
    ins_ack      = 1'b0;
    game_addLine = 1'b0;
    tests++; if (pending !== 3'd7) begin fails++; $display("FAIL collide_pending: got %0d expected 7", pending); end
    tests++; if (ins_row !== 10'h1FF) begin fails++; $display("FAIL hole9_row: got %h expected 1ff", ins_row); end
    tick();
    ins_ack = 1'b1;
    tick();
    ins_ack = 1'b0;
    tests++; if (ins_row !== 10'h3FB) begin fails++; $display("FAIL hole_wrap_row: got %h expected 3fb", ins_row); end
    tests++; if (pending !== 3'd6) begin fails++; $display("FAIL ovf_pending_ack: got %0d expected 6", pending); end
  endtask

  task automatic test_reset_mid_send;
    int highs;
    highs = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulse_clear(4);
    clear_done = 1'b1;
    tick();
    clear_done = 1'b0;
    tests++; if (game_sendLine !== 1'b1) begin fails++; $display("FAIL mid_pulse_t1: got %b expected 1", game_sendLine); end
    game_addLine = 1'b1;
    tick();
    game_addLine = 1'b0;
    tests++; if (pending !== 3'd1) begin fails++; $display("FAIL mid_pending_t2: got %0d expected 1", pending); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (game_sendLine !== 1'b0) highs++;
      tick();
    end
    tests++; if (highs !== 0) begin fails++; $display("FAIL mid_pulses_after_rst: got %0d expected 0", highs); end
    tests++; if (pending !== 3'd0) begin fails++; $display("FAIL mid_pending_lost: got %0d expected 0", pending); end
    tests++; if (ins_req !== 1'b0) begin fails++; $display("FAIL mid_ins_req: got %b expected 0", ins_req); end
    tests++; if (ins_row !== 10'h3FE) begin fails++; $display("FAIL mid_ins_row: got %h expected 3fe", ins_row); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL mid_overflow: got %b expected 0", overflow); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_double_clear();
    test_four_row(4, 1'b0);
    test_four_row(3, 1'b1);
    test_four_row(6, 1'b0);
    test_cancel_insert();
    test_overflow();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
